fp_adder_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754 adder/subtractor with valid/ready handshake on both sides.

---
 rtl/fp_adder_pipe.sv | 241 ++++++++++++++++++++++++
 tb/tb_fp_adder_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_pipe.sv
// fp_adder_pipe: 3-stage pipelined IEEE-754 adder/subtractor with round-to-nearest-even
// and full subnormal support. Valid/ready handshake on both sides; the whole pipe
// holds while the output is stalled.
// Optional feature: define FP_ADDER_FLAGS_EN to add the out_flags port
// {invalid, overflow, underflow, inexact, zero}, pipelined alongside the result.
module fp_adder_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sub,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result
`ifdef FP_ADDER_FLAGS_EN
    ,
    output logic [4:0]   out_flags
`endif
);
    localparam int EB   = MAN_W + 4;     // aligned magnitude: {hidden, frac, G, R, S}
    localparam int SW   = MAN_W + 5;     // magnitude plus carry
    localparam int LZ_W = $clog2(SW);
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
    localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(EB);
    localparam logic [EXP_W:0]   EXP_INC   = (EXP_W + 1)'(1);

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- Stage 1: unpack, classify, swap, align ----------------
    logic             x_s, y_s, a_s, b_s, swap;
    logic [EXP_W-1:0] x_e, y_e, a_e, b_e, a_ee, b_ee, shamt;
    logic [MAN_W-1:0] x_f, y_f, a_f, b_f;
    logic             x_nan, y_nan, x_inf, y_inf;
    logic [EB-1:0]    b_ext, b_al;
    logic             sp;
    logic [W-1:0]     sp_res;
`ifdef FP_ADDER_FLAGS_EN
    logic             sp_inv, s1_inv, s2_inv;
`endif

    // Classify operands, order by magnitude and align the smaller one with sticky collection
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        x_s   = in_x[W-1];
        x_e   = in_x[W-2:MAN_W];
        x_f   = in_x[MAN_W-1:0];
        y_s   = in_y[W-1] ^ in_sub;
        y_e   = in_y[W-2:MAN_W];
        y_f   = in_y[MAN_W-1:0];
        x_nan = (x_e == EXP_ONES) && (x_f != '0);
        y_nan = (y_e == EXP_ONES) && (y_f != '0);
        x_inf = (x_e == EXP_ONES) && (x_f == '0);
        y_inf = (y_e == EXP_ONES) && (y_f == '0);

        swap  = {y_e, y_f} > {x_e, x_f};
        a_s   = swap ? y_s : x_s;
        a_e   = swap ? y_e : x_e;
        a_f   = swap ? y_f : x_f;
        b_s   = swap ? x_s : y_s;
        b_e   = swap ? x_e : y_e;
        b_f   = swap ? x_f : y_f;
        // Subnormals share the exponent of the smallest normal.
        a_ee  = (a_e == '0) ? EXP_ONE : a_e;
        b_ee  = (b_e == '0) ? EXP_ONE : b_e;
        shamt = a_ee - b_ee;
        b_ext = {(b_e != '0), b_f, 3'b000};
        if (shamt >= SHIFT_LIM)
            b_al = {{(EB-1){1'b0}}, (b_ext != '0)};
        else
            b_al = (b_ext >> shamt)
                 | {{(EB-1){1'b0}}, ((b_ext & ~({EB{1'b1}} << shamt)) != '0)};

        sp     = 1'b0;
        sp_res = '0;
        if (x_nan) begin
            sp     = 1'b1;
            sp_res = {x_s, EXP_ONES, 1'b1, x_f[MAN_W-2:0]};
        end else if (y_nan) begin
            sp     = 1'b1;
            sp_res = {in_y[W-1], EXP_ONES, 1'b1, y_f[MAN_W-2:0]};
        end else if (x_inf && y_inf && (x_s != y_s)) begin
            sp     = 1'b1;
            sp_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (x_inf) begin
            sp     = 1'b1;
            sp_res = {x_s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (y_inf) begin
            sp     = 1'b1;
            sp_res = {y_s, EXP_ONES, {MAN_W{1'b0}}};
        end
`ifdef FP_ADDER_FLAGS_EN
        sp_inv = (x_nan && !x_f[MAN_W-1]) || (y_nan && !y_f[MAN_W-1])
              || (!x_nan && !y_nan && x_inf && y_inf && (x_s != y_s));
`endif
    end

    logic             s1_valid, s1_sp, s1_sign, s1_sub, s1_zsign;
    logic [W-1:0]     s1_sp_res;
    logic [EXP_W-1:0] s1_ea;
    logic [EB-1:0]    s1_ma, s1_mb;

    // ---------------- Stage 2: effective add/sub and leading-zero count ----------------
    logic [SW-1:0]   sum;
    logic [LZ_W-1:0] lzc;

    // Add or subtract aligned magnitudes (|A|>=|B| so the difference is never negative) and count leading zeros
    always_comb begin
        sum = s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb}) : ({1'b0, s1_ma} + {1'b0, s1_mb});
        lzc = LZ_W'(EB);
        for (int i = 0; i < EB; i++)
            if (sum[i]) lzc = LZ_W'(EB - 1 - i);
    end

    logic             s2_valid, s2_sp, s2_sign, s2_zsign;
    logic [W-1:0]     s2_sp_res;
    logic [EXP_W-1:0] s2_ea;
    logic [SW-1:0]    s2_sum;
    logic [LZ_W-1:0]  s2_lzc;

    // Datapath registers for stages 1 and 2, held while stalled
    // NOTE: datapath registers carry no reset; only the valid bits and the output register need defined values.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_sp     <= sp;
            s1_sp_res <= sp_res;
            s1_sign   <= a_s;
            s1_sub    <= a_s ^ b_s;
            s1_zsign  <= a_s & b_s;
            s1_ea     <= a_ee;
            s1_ma     <= {(a_e != '0), a_f, 3'b000};
            s1_mb     <= b_al;
            s2_sp     <= s1_sp;
            s2_sp_res <= s1_sp_res;
            s2_sign   <= s1_sign;
            s2_zsign  <= s1_zsign;
            s2_ea     <= s1_ea;
            s2_sum    <= sum;
            s2_lzc    <= lzc;
`ifdef FP_ADDER_FLAGS_EN
            s1_inv    <= sp_inv;
            s2_inv    <= s1_inv;
`endif
        end
    end

    // ---------------- Stage 3: normalise, round, pack ----------------
    logic [EXP_W-1:0] lzc_e, ea_m1, sh;
    logic [EB-1:0]    norm;
    logic [EXP_W:0]   exp_pre, exp_fin;
    logic [MAN_W+1:0] rounded;
    logic [MAN_W-1:0] frac;
    logic             g, r, s, inc, ovf;
    logic [W-1:0]     res;

    // Normalise (carry right-shift or bounded left-shift into subnormal range), RNE round, pack
    always_comb begin
        lzc_e = EXP_W'(s2_lzc);
        ea_m1 = s2_ea - EXP_ONE;
        sh    = '0;
        if (s2_sum[EB]) begin
            norm    = {s2_sum[EB:2], s2_sum[1] | s2_sum[0]};
            exp_pre = {1'b0, s2_ea} + EXP_INC;
        end else begin
            sh      = (lzc_e < ea_m1) ? lzc_e : ea_m1;
            norm    = s2_sum[EB-1:0] << sh;
            exp_pre = norm[EB-1] ? {1'b0, s2_ea - sh} : '0;
        end
        g       = norm[2];
        r       = norm[1];
        s       = norm[0];
        inc     = g & (r | s | norm[3]);
        rounded = {1'b0, norm[EB-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        if (rounded[MAN_W+1]) begin
            exp_fin = exp_pre + EXP_INC;
            frac    = rounded[MAN_W:1];
        end else begin
            // A subnormal that rounds up into the hidden bit becomes the smallest normal.
            exp_fin = ((exp_pre == '0) && rounded[MAN_W]) ? EXP_INC : exp_pre;
            frac    = rounded[MAN_W-1:0];
        end
        ovf = exp_fin >= {1'b0, EXP_ONES};

        if (s2_sp)
            res = s2_sp_res;
        else if (s2_sum == '0)
            res = {s2_zsign, {(W-1){1'b0}}};
        else if (ovf)
            res = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        else
            res = {s2_sign, exp_fin[EXP_W-1:0], frac};
    end

`ifdef FP_ADDER_FLAGS_EN
    logic [4:0] flags;

    // Exception flags {invalid, overflow, underflow, inexact, zero} for the packed result
    always_comb begin
        flags = '0;
        if (s2_sp) begin
            flags[4] = s2_inv;
        end else if (s2_sum != '0) begin
            flags[3] = ovf;
            flags[2] = (exp_pre == '0) && (g | r | s);
            flags[1] = g | r | s | ovf;
        end
        flags[0] = (res[W-2:0] == '0);
    end
`endif

    // Stage valids and output register: cleared by reset, advance together unless stalled
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
`ifdef FP_ADDER_FLAGS_EN
            out_flags  <= '0;
`endif
        end else if (!stall) begin
            s1_valid   <= in_valid;
            s2_valid   <= s1_valid;
            out_valid  <= s2_valid;
            out_result <= res;
`ifdef FP_ADDER_FLAGS_EN
            out_flags  <= flags;
`endif
        end
    end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// tb_fp_adder_pipe: directed self-checking bench for fp_adder_pipe (binary32).
// Flag checks are included when FP_ADDER_FLAGS_EN is defined.
module tb_fp_adder_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_sub;
    logic [W-1:0] in_x, in_y;
    logic         out_valid, out_ready;
    logic [W-1:0] out_result;
`ifdef FP_ADDER_FLAGS_EN
    logic [4:0]   out_flags;
    logic [4:0]   last_flags;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Stream vectors: X, Y, sub, expected result
    logic [31:0] sx [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000,
                            32'hC0000000, 32'h3F000000, 32'h41200000, 32'h7F800000};
    logic [31:0] sy [8] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40000000,
                            32'hC0000000, 32'h3F000000, 32'h40A00000, 32'h3F800000};
    logic        ss [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] se [8] = '{32'h40000000, 32'h40A00000, 32'h40000000, 32'hBF800000,
                            32'hC0800000, 32'h3F800000, 32'h41700000, 32'h7F800000};

    always #5 clk = ~clk;

    fp_adder_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sub     (in_sub),
        .in_x       (in_x),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef FP_ADDER_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    // One isolated operation: checks 3-cycle latency, result, and that it is not repeated.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic sub, input logic [31:0] exp_res);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_sub   = sub;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check(tag, out_result, exp_res);
`ifdef FP_ADDER_FLAGS_EN
        last_flags = out_flags;
`endif
        @(negedge clk);
        check({tag, " single"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  sent, got, cyc;
        logic acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_result", out_result, 32'h0);
`ifdef FP_ADDER_FLAGS_EN
        check("reset out_flags", 32'(out_flags), 32'd0);
`endif
        rst = 1'b0;

        run_op("1+1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        run_op("1.5+2.25", 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000);
        run_op("tie even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
`ifdef FP_ADDER_FLAGS_EN
        check("tie even flags", 32'(last_flags), 32'h02);
`endif
        run_op("tie odd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
        run_op("1-1", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
`ifdef FP_ADDER_FLAGS_EN
        check("1-1 flags", 32'(last_flags), 32'h01);
`endif
        run_op("denorm add", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002);
        run_op("min normal-denorm", 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF);
        run_op("inf-inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000);
`ifdef FP_ADDER_FLAGS_EN
        check("inf-inf flags", 32'(last_flags), 32'h10);
`endif
        run_op("max+max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
`ifdef FP_ADDER_FLAGS_EN
        check("max+max flags", 32'(last_flags), 32'h0A);
`endif
        run_op("1-inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000);
        run_op("snan x", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00001);
`ifdef FP_ADDER_FLAGS_EN
        check("snan x flags", 32'(last_flags), 32'h10);
`endif
        run_op("qnan y", 32'h3F800000, 32'hFFC00000, 1'b0, 32'hFFC00000);
        run_op("-0+-0", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
        run_op("3+-0", 32'h40400000, 32'h80000000, 1'b0, 32'h40400000);

        // Back-to-back stream with out_ready low for two cycles once the pipe is full
        sent = 0;
        got  = 0;
        cyc  = 0;
        acc  = 1'b0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (acc) sent++;
            out_ready = !(cyc == 6 || cyc == 7);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_x   = sx[sent];
                in_y   = sy[sent];
                in_sub = ss[sent];
            end
            #1;
            acc = in_valid & in_ready;
            if (cyc == 6 || cyc == 7) begin
                check("stall in_ready", 32'(in_ready), 32'd0);
                check("stall out_valid", 32'(out_valid), 32'd1);
            end
            if (out_valid) begin
                check($sformatf("stream[%0d]", got), out_result, se[got]);
                if (out_ready) got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream count", 32'(got), 32'd8);
        check("stream cycles", 32'(cyc), 32'd13);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stream drained", 32'(out_valid), 32'd0);
        end

        // Reset with three operations in flight
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x     = sx[i];
            in_y     = sy[i];
            in_sub   = ss[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("flush pre valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush out_result", out_result, 32'h0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post reset idle", 32'(out_valid), 32'd0);
        end
        run_op("post reset 10+5", 32'h41200000, 32'h40A00000, 1'b0, 32'h41700000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
